// File: rtl/led_event_blinker_pkg.sv
// Shared types and default timing constants for the LED event blinker.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // 10 ms tick at 100 MHz, 250 ms on, 250 ms off
  localparam int DEF_CLK_DIV   = 1000000;
  localparam int DEF_ON_TICKS  = 25;
  localparam int DEF_OFF_TICKS = 25;

endpackage

// File: rtl/led_event_blinker_tick_prescaler.sv
// Clock-enable generator: tick is high for one clk out of every DIV.
// clr restarts the count so a phase that begins on clr lasts whole ticks.
module tick_prescaler
  import led_blink_pkg::*;
#(
  parameter int DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            W    = $clog2(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Free-running 0..DIV-1 count, restarted on clr
  always_ff @(posedge clk) begin
    if (!rst_n || clr || tick) cnt_q <= '0;
    else                       cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event pulses into fixed-length LED blinks.
// Events arriving mid-blink are counted and replayed back to back.
// Build option LED_EVENT_BLINKER_QUEUE_EN: when defined, up to
// 2^CNT_W-1 events queue; otherwise pending is a single held flag.
//
// state | meaning
// IDLE  | LED dark, nothing pending
// ON    | LED lit, counting ON_TICKS
// GAP   | LED dark, counting OFF_TICKS before the next blink or IDLE
module led_event_blinker
  import led_blink_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_in,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int DUR_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

`ifdef LED_EVENT_BLINKER_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
`else
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(1);
`endif

  blink_state_t     state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             led_q, led_d;
  logic             ovf_q, ovf_d;
  logic             deq;
  logic             clr;
  logic             tick;

  tick_prescaler #(.DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // State, duration, queue and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dur_q   <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, duration countdown, dequeue and pending/overflow update
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    deq     = 1'b0;
    clr     = 1'b0;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = ON;
          dur_d   = DUR_W'(ON_TICKS);
          deq     = 1'b1;
          clr     = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            state_d = GAP;
            dur_d   = DUR_W'(OFF_TICKS);
            clr     = 1'b1;
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            // Chain straight into the next blink so IDLE is skipped
            if (pend_q != '0) begin
              state_d = ON;
              dur_d   = DUR_W'(ON_TICKS);
              deq     = 1'b1;
              clr     = 1'b1;
            end else begin
              state_d = IDLE;
              dur_d   = '0;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        dur_d   = '0;
      end
    endcase

    // An event that coincides with a dequeue takes the freed slot
    if (ev_in && !deq) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + CNT_W'(1);
    end else if (!ev_in && deq) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  assign led_d    = (state_d == ON);
  assign led      = led_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || (pend_q != '0);

endmodule
